// File: rtl/superpixel_rect_walker_pkg.sv
// Shared types and helpers for the superpixel rectangle walker.
package superpixel_rect_walker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWalk
  } state_t;

  // Bottom-right corner clipped to the last visible pixel.
  function automatic int unsigned clip_max(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/superpixel_rect_walker_spx_rect_calc.sv
// Maps a superpixel coordinate to its clipped pixel rectangle and an off-screen flag.
module superpixel_rect_walker_spx_rect_calc
  import superpixel_rect_walker_pkg::*;
#(
  parameter int unsigned SPIXEL_X_WIDTH = 6,
  parameter int unsigned SPIXEL_Y_WIDTH = 6,
  parameter int unsigned PIXEL_X_WIDTH  = 10,
  parameter int unsigned PIXEL_Y_WIDTH  = 9,
  parameter int unsigned PIXEL_X_MAX    = 639,
  parameter int unsigned PIXEL_Y_MAX    = 479,
  parameter int unsigned SPIXEL_W       = 10,
  parameter int unsigned SPIXEL_H       = 10
) (
  input  logic                      clk,
  input  logic                      load,
  input  logic [SPIXEL_X_WIDTH-1:0] in_x,
  input  logic [SPIXEL_Y_WIDTH-1:0] in_y,
  output logic [PIXEL_X_WIDTH-1:0]  tlx,
  output logic [PIXEL_Y_WIDTH-1:0]  tly,
  output logic [PIXEL_X_WIDTH-1:0]  brx,
  output logic [PIXEL_Y_WIDTH-1:0]  bry,
  output logic                      offscr
);

  localparam int unsigned XW = PIXEL_X_WIDTH + SPIXEL_X_WIDTH;
  localparam int unsigned YW = PIXEL_Y_WIDTH + SPIXEL_Y_WIDTH;

  logic [XW-1:0] tlx_w, brx_w;
  logic [YW-1:0] tly_w, bry_w;

  // Full-width products so an off-screen corner is never wrapped back on-screen.
  always_comb begin
    tlx_w = XW'(in_x) * XW'(SPIXEL_W);
    tly_w = YW'(in_y) * YW'(SPIXEL_H);
    brx_w = tlx_w + XW'(SPIXEL_W - 1);
    bry_w = tly_w + YW'(SPIXEL_H - 1);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tlx    <= PIXEL_X_WIDTH'(tlx_w);
      tly    <= PIXEL_Y_WIDTH'(tly_w);
      brx    <= PIXEL_X_WIDTH'(clip_max(32'(brx_w), PIXEL_X_MAX));
      bry    <= PIXEL_Y_WIDTH'(clip_max(32'(bry_w), PIXEL_Y_MAX));
      offscr <= (32'(tlx_w) > PIXEL_X_MAX) || (32'(tly_w) > PIXEL_Y_MAX);
    end
  end

endmodule

// File: rtl/superpixel_rect_walker.sv
// Expands one superpixel request into a raster-ordered stream of pixel coordinates.
module superpixel_rect_walker
  import superpixel_rect_walker_pkg::*;
#(
  parameter int unsigned SPIXEL_X_WIDTH = 6,
  parameter int unsigned SPIXEL_Y_WIDTH = 6,
  parameter int unsigned PIXEL_X_WIDTH  = 10,
  parameter int unsigned PIXEL_Y_WIDTH  = 9,
  parameter int unsigned PIXEL_X_MAX    = 639,
  parameter int unsigned PIXEL_Y_MAX    = 479,
  parameter int unsigned SPIXEL_W       = 10,
  parameter int unsigned SPIXEL_H       = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SPIXEL_X_WIDTH-1:0] in_x,
  input  logic [SPIXEL_Y_WIDTH-1:0] in_y,
  input  logic                      in_border,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIXEL_X_WIDTH-1:0]  out_x,
  output logic [PIXEL_Y_WIDTH-1:0]  out_y,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      err_offscr
);

  logic [PIXEL_X_WIDTH-1:0] tlx, brx, nx;
  logic [PIXEL_Y_WIDTH-1:0] tly, bry, ny;
  logic                     offscr, border, full_row, accept;
  state_t                   state;

  assign accept = in_valid && in_ready;

  superpixel_rect_walker_spx_rect_calc #(
    .SPIXEL_X_WIDTH(SPIXEL_X_WIDTH),
    .SPIXEL_Y_WIDTH(SPIXEL_Y_WIDTH),
    .PIXEL_X_WIDTH (PIXEL_X_WIDTH),
    .PIXEL_Y_WIDTH (PIXEL_Y_WIDTH),
    .PIXEL_X_MAX   (PIXEL_X_MAX),
    .PIXEL_Y_MAX   (PIXEL_Y_MAX),
    .SPIXEL_W      (SPIXEL_W),
    .SPIXEL_H      (SPIXEL_H)
  ) u_spx_rect_calc (
    .clk   (clk),
    .load  (accept),
    .in_x  (in_x),
    .in_y  (in_y),
    .tlx   (tlx),
    .tly   (tly),
    .brx   (brx),
    .bry   (bry),
    .offscr(offscr)
  );

  // Next beat position; interior border rows jump from the left edge straight to the right edge.
  always_comb begin
    full_row = !border || (out_y == tly) || (out_y == bry);
    nx       = out_x;
    ny       = out_y;
    if (full_row) begin
      if (out_x == brx) begin
        nx = tlx;
        ny = out_y + 1'b1;
      end else begin
        nx = out_x + 1'b1;
      end
    end else if ((out_x == tlx) && (brx != tlx)) begin
      nx = brx;
    end else begin
      nx = tlx;
      ny = out_y + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      err_offscr <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      border     <= 1'b0;
    end else begin
      err_offscr <= 1'b0;
      unique case (state)
        StIdle: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            border   <= in_border;
            state    <= StLoad;
          end
        end
        StLoad: begin
          if (offscr) begin
            err_offscr <= 1'b1;
            in_ready   <= 1'b1;
            state      <= StIdle;
          end else begin
            out_valid <= 1'b1;
            out_x     <= tlx;
            out_y     <= tly;
            out_first <= 1'b1;
            out_last  <= (tlx == brx) && (tly == bry);
            state     <= StWalk;
          end
        end
        StWalk: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_first <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= StIdle;
            end else begin
              out_x     <= nx;
              out_y     <= ny;
              out_first <= 1'b0;
              out_last  <= (nx == brx) && (ny == bry);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
